// File: rtl/s2_rr_arbiter_pkg.sv
// Shared types and helpers for the S2 round-robin arbiter.
// Holds the requester count, select width, FSM encoding and the rotating
// priority search used by s2_rr_arbiter.
package s2_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        OUT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] winner;
    } pick_t;

    // Returns the first requester at or after ptr (mod NUM_REQ) whose req bit
    // is set and whose mask bit is clear. The search runs from the farthest
    // offset back to ptr so the nearest candidate is the one that sticks.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [NUM_REQ-1:0] mask,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t              p;
        logic [NUM_REQ-1:0] eligible;
        logic [SEL_W-1:0]   idx;
        p.found  = 1'b0;
        p.winner = ptr;
        eligible = req & ~mask;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (eligible[idx]) begin
                p.found  = 1'b1;
                p.winner = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/s2_rr_arbiter_s2.sv
// S2 registered 4:1 select cell.
// SEL1 = A1 | B1, SEL0 = A0 & B0; Q captures D[{SEL1,SEL0}] on every rising
// edge and clears asynchronously on CLR.
module s2_rr_arbiter_s2 #(
    parameter int SIZE = 5
) (
    input  logic            clk,
    input  logic            CLR,
    input  logic            A0,
    input  logic            A1,
    input  logic            B0,
    input  logic            B1,
    input  logic [SIZE-1:0] D0,
    input  logic [SIZE-1:0] D1,
    input  logic [SIZE-1:0] D2,
    input  logic [SIZE-1:0] D3,
    output logic [SIZE-1:0] Q
);

    logic [1:0] sel;

    assign sel = {A1 | B1, A0 & B0};

    // Capture the selected word every cycle.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            Q <= '0;
        end else begin
            case (sel)
                2'd0:    Q <= D0;
                2'd1:    Q <= D1;
                2'd2:    Q <= D2;
                default: Q <= D3;
            endcase
        end
    end

endmodule

// File: rtl/s2_rr_arbiter.sv
// Round-robin controller sharing one S2 select cell among four requesters.
// Drives the S2 selects from grant_q, presents the captured word on a
// valid/ready port and pulses ack to the winner when its word is consumed.
// Optional build macro: ARB_STATS_EN adds grant_cnt (four saturating 8-bit
// per-requester ack counters).
//
// state | meaning
// IDLE  | no transfer; arbitrate from ptr when any req is set
// SEL   | selects = grant_q, S2 captures the winning word at the closing edge
// OUT   | out_valid; on out_ready ack winner and re-arbitrate with it masked
module s2_rr_arbiter
    import s2_arb_pkg::*;
#(
    parameter int SIZE = 5
) (
    input  logic               clk,
    input  logic               CLR,
    input  logic [NUM_REQ-1:0] req,
    input  logic [SIZE-1:0]    d0,
    input  logic [SIZE-1:0]    d1,
    input  logic [SIZE-1:0]    d2,
    input  logic [SIZE-1:0]    d3,
    output logic [NUM_REQ-1:0] ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE-1:0]    out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]        grant_cnt
`endif
);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] grant_oh;
    logic               take;
    pick_t              pick_idle, pick_out;

    assign grant_oh  = NUM_REQ'(1) << grant_q;
    assign pick_idle = rr_pick(req, '0, ptr_q);
    // The consumed requester still holds req this cycle, so it is masked and
    // the search starts just past it, matching the pointer update.
    assign pick_out  = rr_pick(req, grant_oh, grant_q + SEL_W'(1));

    assign out_src = grant_q;
    assign busy    = (state_q != IDLE);

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (take) begin
                ptr_q <= grant_q + SEL_W'(1);
            end
        end
    end

    // Next-state, grant selection and handshake outputs.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        out_valid = 1'b0;
        ack       = '0;
        take      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    grant_d = pick_idle.winner;
                    state_d = SEL;
                end
            end
            SEL: begin
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    take = 1'b1;
                    ack  = grant_oh;
                    if (pick_out.found) begin
                        grant_d = pick_out.winner;
                        state_d = SEL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    s2_rr_arbiter_s2 #(.SIZE(SIZE)) u_s2 (
        .clk (clk),
        .CLR (CLR),
        .A0  (grant_q[0]),
        .A1  (grant_q[1]),
        .B0  (grant_q[0]),
        .B1  (grant_q[1]),
        .D0  (d0),
        .D1  (d1),
        .D2  (d2),
        .D3  (d3),
        .Q   (out_data)
    );

`ifdef ARB_STATS_EN
    logic [7:0] cnt_q [NUM_REQ];

    // Per-requester ack counters, saturating at 255.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i] && (cnt_q[i] != 8'hFF)) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Pack the counters into the flat output, field i at bits 8i+7:8i.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[8*i +: 8] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_s2_rr_arbiter.sv
// Self-checking bench for s2_rr_arbiter: expected (source, word) pairs are
// queued as requests are driven and popped on each out_valid/out_ready
// handshake.
module tb_s2_rr_arbiter;

    logic       clk = 1'b0;
    logic       CLR;
    logic [3:0] req;
    logic [4:0] d0, d1, d2, d3;
    logic [3:0] ack;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic [1:0] out_src;
    logic       busy;
`ifdef ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] src;
        logic [4:0] data;
    } sb_t;

    sb_t sb[$];

    s2_rr_arbiter #(.SIZE(5)) dut (
        .clk       (clk),
        .CLR       (CLR),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .busy      (busy)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] src, input logic [4:0] data);
        sb_t e;
        e.src  = src;
        e.data = data;
        sb.push_back(e);
    endtask

    // Steps cycles until n words are consumed or the budget runs out.
    // keep=0 drops the winner's req after its ack; first_lat checks the
    // cycle of the first handshake; b2b checks two-cycle spacing.
    task automatic drain(input int n, input bit keep, input int first_lat,
                         input bit b2b, input int budget);
        int  got;
        int  cyc;
        int  last;
        int  drop;
        sb_t e;
        got  = 0;
        cyc  = 0;
        last = 0;
        while (got < n && cyc < budget) begin
            #1;
            drop = -1;
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                end else begin
                    e.src  = '0;
                    e.data = '0;
                end
                chk("data", 32'(out_data), 32'(e.data));
                chk("src", 32'(out_src), 32'(e.src));
                chk("ack", 32'(ack), 32'(4'b0001 << e.src));
                if (got == 0 && first_lat >= 0) chk("latency", cyc, first_lat);
                if (got > 0 && b2b) chk("spacing", cyc - last, 2);
                last = cyc;
                got++;
                if (!keep) drop = int'(e.src);
            end else begin
                chk("idle_ack", 32'(ack), 0);
            end
            tick();
            if (drop >= 0) req[drop[1:0]] = 1'b0;
            cyc++;
        end
        chk("words", got, n);
    endtask

    initial begin
        CLR       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_src", 32'(out_src), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);

        // All four requesting: strict rotation, then requester 0 again.
        CLR = 1'b0;
        d0 = 5'd1; d1 = 5'd2; d2 = 5'd3; d3 = 5'd4;
        req = 4'b1111;
        out_ready = 1'b1;
        push(0, 5'd1); push(1, 5'd2); push(2, 5'd3); push(3, 5'd4); push(0, 5'd1);
        drain(5, 1'b1, 2, 1'b1, 30);
        out_ready = 1'b0;
        req = '0;
        tick();
        CLR = 1'b1;
        #1;
        chk("rr_clr_busy", 32'(busy), 0);
        chk("rr_clr_valid", 32'(out_valid), 0);
        tick();
        CLR = 1'b0;

        // CLR mid-OUT with requester 1 pending.
        d1 = 5'h0A;
        req = 4'b0010;
        tick();
        tick();
        #1;
        chk("pre_clr_valid", 32'(out_valid), 1);
        chk("pre_clr_data", 32'(out_data), 32'h0A);
        CLR = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_data", 32'(out_data), 0);
        chk("clr_src", 32'(out_src), 0);
        chk("clr_ack", 32'(ack), 0);
        chk("clr_busy", 32'(busy), 0);
        tick();
        CLR = 1'b0;
        d0 = 5'h0C;
        req = 4'b0001;
        push(0, 5'h0C);
        drain(1, 1'b0, 2, 1'b0, 10);

        // Single request from requester 2 (ptr was 1, becomes 3).
        d2 = 5'h15;
        req = 4'b0100;
        push(2, 5'h15);
        drain(1, 1'b0, 2, 1'b0, 10);

        // Wrap: ptr=3 with 1001 grants 3 then 0, leaving ptr at 1.
        d0 = 5'h11; d3 = 5'h13;
        req = 4'b1001;
        push(3, 5'h13); push(0, 5'h11);
        drain(2, 1'b0, 2, 1'b1, 20);

        // ptr=1 with 0011 grants 1 before 0.
        d0 = 5'h05; d1 = 5'h06;
        req = 4'b0011;
        push(1, 5'h06); push(0, 5'h05);
        drain(2, 1'b0, 2, 1'b1, 20);

        // Backpressure: five stalled cycles, then a single ack.
        out_ready = 1'b0;
        d1 = 5'h1F;
        req = 4'b0010;
        push(1, 5'h1F);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'h1F);
            chk("bp_ack", 32'(ack), 0);
            tick();
        end
        out_ready = 1'b1;
        drain(1, 1'b0, 0, 1'b0, 10);

        // Winner drops req before ack: transfer still completes.
        out_ready = 1'b0;
        d2 = 5'h07;
        req = 4'b0100;
        push(2, 5'h07);
        tick();
        tick();
        req = '0;
        tick();
        #1;
        chk("viol_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        drain(1, 1'b0, 0, 1'b0, 10);

        // out_ready while idle does nothing.
        out_ready = 1'b1;
        req = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_ready_ack", 32'(ack), 0);
            chk("idle_ready_busy", 32'(busy), 0);
            tick();
        end

`ifdef ARB_STATS_EN
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        #1;
        chk("cnt_clr", grant_cnt, 0);
        d0 = 5'h19;
        req = 4'b0001;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) push(0, 5'h19);
        drain(300, 1'b1, 2, 1'b0, 1200);
        req = '0;
        tick();
        #1;
        chk("cnt_sat", grant_cnt, 32'h0000_00FF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
